// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

    // FSM encoding: idle waits for a word, shift drives its bits onto the line.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit order captured with each word.
    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one word: counts 0..WIDTH-1 and flags the last bit.
module piso_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     is_last
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign is_last = (count == LAST);

    // Clear wins over enable; the count never runs past the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !is_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load, per-word bit
// order, bit-rate strobe and first/last-bit framing.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             serial_data_out,
    output logic             serial_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic             dir;
    logic [CW-1:0]    bit_cnt;
    logic             is_last;
    logic             wrap;
    logic             accept;
    logic             advance;

    // Load handshake: a word transfers on a rising edge where in_valid and
    // in_ready are both 1. in_ready never looks at in_valid; it is high while
    // idle and on the strobed last bit, so the next word can follow with no gap.
    // The producer holds parallel_data_in/msb_first until the transfer happens.
    assign wrap     = (state == ST_SHIFT) && is_last && shift_en;
    assign in_ready = (state == ST_IDLE) || wrap;
    assign accept   = in_valid && in_ready;
    assign advance  = (state == ST_SHIFT) && shift_en && !is_last;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || wrap),
        .enable (advance),
        .count  (bit_cnt),
        .is_last(is_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and line-side outputs; the line rests at IDLE_LEVEL when idle.
    always_comb begin
        state_next      = state;
        serial_data_out = IDLE_LEVEL;
        serial_valid    = 1'b0;
        frame_first     = 1'b0;
        frame_last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                serial_data_out = (dir == ORDER_MSB) ? shreg[WIDTH-1] : shreg[0];
                serial_valid    = 1'b1;
                frame_first     = (bit_cnt == '0);
                frame_last      = is_last;
                if (wrap && !accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = serial_valid;

    // Shift register and captured bit order; shifting moves the next bit
    // toward the output end and zero-fills behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            dir   <= ORDER_LSB;
        end else if (accept) begin
            shreg <= parallel_data_in;
            dir   <= msb_first;
        end else if (advance) begin
            if (dir == ORDER_MSB) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios on an 8-bit
// instance plus randomized streams on 2-, 5- and 16-bit instances, all checked
// against a bit-queue reference model of the line.
module tb_piso_serializer;

    // ---------------- clock ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters / checking task ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- 8-bit instance ----------------
    logic       rst8, v8, m8, s8;
    logic [7:0] d8;
    logic       rdy8, so8, sv8, ff8, fl8, busy8;

    piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
        .clk             (clk),
        .reset           (rst8),
        .parallel_data_in(d8),
        .in_valid        (v8),
        .in_ready        (rdy8),
        .msb_first       (m8),
        .shift_en        (s8),
        .serial_data_out (so8),
        .serial_valid    (sv8),
        .frame_first     (ff8),
        .frame_last      (fl8),
        .busy            (busy8)
    );

    // Reference: bits of the word in flight, in line order; front = bit on the line.
    logic q8[$];
    logic obs_so, obs_sv, obs_ff, obs_fl, obs_rdy;

    // One clock cycle on the 8-bit instance: drive, check against the model, advance.
    task automatic cyc8(input logic rst, input logic v, input logic [7:0] d,
                        input logic m, input logic s);
        logic er;
        @(negedge clk);
        rst8 = rst; v8 = v; d8 = d; m8 = m; s8 = s;
        #1;
        er = (q8.size() == 0) || (q8.size() == 1 && s);
        obs_so = so8; obs_sv = sv8; obs_ff = ff8; obs_fl = fl8; obs_rdy = rdy8;
        check("w8_serial_valid", sv8, q8.size() != 0);
        check("w8_busy", busy8, q8.size() != 0);
        check("w8_data", so8, (q8.size() != 0) ? q8[0] : 1'b0);
        check("w8_first", ff8, q8.size() == 8);
        check("w8_last", fl8, q8.size() == 1);
        check("w8_in_ready", rdy8, er);
        @(posedge clk);
        if (rst) begin
            q8.delete();
        end else begin
            if (q8.size() != 0 && s) void'(q8.pop_front());
            if (v && er) begin
                for (int k = 0; k < 8; k++) q8.push_back(m ? d[7-k] : d[k]);
            end
        end
    endtask

    // ---------------- width sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : gen_sw
        localparam int   W  = (g == 0) ? 2 : (g == 1) ? 5 : 16;
        localparam logic IL = (g == 1) ? 1'b1 : 1'b0;

        logic         rst, v, m, s;
        logic [W-1:0] d;
        logic         rdy, so, sv, ff, fl, bz;
        logic         done;
        logic         q[$];

        piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
            .clk             (clk),
            .reset           (rst),
            .parallel_data_in(d),
            .in_valid        (v),
            .in_ready        (rdy),
            .msb_first       (m),
            .shift_en        (s),
            .serial_data_out (so),
            .serial_valid    (sv),
            .frame_first     (ff),
            .frame_last      (fl),
            .busy            (bz)
        );

        initial begin
            logic er;
            done = 1'b0;
            rst = 1'b1; v = 1'b0; m = 1'b0; s = 1'b0; d = '0;
            repeat (2) @(posedge clk);
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 99) == 0);
                v   = ($urandom_range(0, 1) == 1);
                d   = W'($urandom);
                m   = ($urandom_range(0, 1) == 1);
                s   = ($urandom_range(0, 2) != 0);
                #1;
                er = (q.size() == 0) || (q.size() == 1 && s);
                check($sformatf("w%0d_serial_valid", W), sv, q.size() != 0);
                check($sformatf("w%0d_busy", W), bz, q.size() != 0);
                check($sformatf("w%0d_data", W), so, (q.size() != 0) ? q[0] : IL);
                check($sformatf("w%0d_first", W), ff, q.size() == W);
                check($sformatf("w%0d_last", W), fl, q.size() == 1);
                check($sformatf("w%0d_in_ready", W), rdy, er);
                @(posedge clk);
                if (rst) begin
                    q.delete();
                end else begin
                    if (q.size() != 0 && s) void'(q.pop_front());
                    if (v && er) begin
                        for (int k = 0; k < W; k++) q.push_back(m ? d[W-1-k] : d[k]);
                    end
                end
            end
            done = 1'b1;
        end
    end

    // ---------------- directed + random sequence on the 8-bit instance ----------------
    initial begin
        logic [7:0]  pat;
        logic [15:0] seq;
        logic        all_done;

        // Reset held two cycles with a word offered: nothing may be taken.
        rst8 = 1'b1; v8 = 1'b1; d8 = 8'hAA; m8 = 1'b0; s8 = 1'b1;
        repeat (2) @(posedge clk);
        cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("reset_serial_valid", obs_sv, 1'b0);
        check("reset_idle_level", obs_so, 1'b0);
        check("reset_in_ready", obs_rdy, 1'b1);

        // LSB-first 8'h1E.
        pat = 8'h1E;
        cyc8(1'b0, 1'b1, 8'h1E, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
            check("lsb_bit", obs_so, pat[i]);
            check("lsb_first", obs_ff, i == 0);
            check("lsb_last", obs_fl, i == 7);
        end
        cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("lsb_then_idle", obs_sv, 1'b0);

        // MSB-first 8'h1E, then 8'hF0 LSB-first offered on the last bit.
        seq = 16'hF078;
        cyc8(1'b0, 1'b1, 8'h1E, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc8(1'b0, i == 7, (i == 7) ? 8'hF0 : 8'($urandom), 1'b0, 1'b1);
            check("b2b_bit", obs_so, seq[i]);
            check("b2b_valid", obs_sv, 1'b1);
            if (i < 15) check("b2b_in_ready", obs_rdy, i == 7);
        end
        cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("b2b_then_idle", obs_sv, 1'b0);

        // Rate control: strobe every 4th cycle, 8'hA5 LSB-first; data and an
        // early in_valid during the word must not disturb it.
        pat = 8'hA5;
        cyc8(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            cyc8(1'b0, (i >= 8 && i < 16), 8'($urandom), ($urandom_range(0, 1) == 1),
                 (i % 4) == 3);
            check("rate_bit", obs_so, pat[i/4]);
            check("rate_first", obs_ff, i < 4);
            check("rate_in_ready", obs_rdy, i == 31);
        end
        cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rate_then_idle", obs_sv, 1'b0);

        // Reset after three bits of 8'hFF, with a word offered in the reset cycle.
        cyc8(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            check("midrst_bit", obs_so, 1'b1);
        end
        cyc8(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        cyc8(1'b0, 1'b1, 8'h81, 1'b1, 1'b1);
        check("midrst_valid", obs_sv, 1'b0);
        check("midrst_idle_level", obs_so, 1'b0);
        check("midrst_in_ready", obs_rdy, 1'b1);
        cyc8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("restart_first", obs_ff, 1'b1);
        check("restart_bit", obs_so, 1'b1);

        // Randomized traffic on the 8-bit instance.
        for (int i = 0; i < 400; i++) begin
            cyc8($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        // Wait, bounded, for the width sweeps to finish.
        all_done = 1'b0;
        for (int i = 0; i < 3000 && !all_done; i++) begin
            @(posedge clk);
            all_done = gen_sw[0].done && gen_sw[1].done && gen_sw[2].done;
        end
        check("sweep_done", all_done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
